// File: rtl/xoodoo_perm_ctrl_sca.sv
// Pass sequencer for the two-share Xoodoo round datapath: load, fetch randomness, run, capture, repeat.
// Optional randomness prefetch during RUN is enabled by defining XOODOO_CTRL_RND_PREFETCH_EN.
module xoodoo_perm_ctrl_sca #(
  parameter int          NUM_ROUNDS       = 12,
  parameter int          ROUNDS_PER_CYCLE = 1,
  parameter int          PASS_LAT         = 2,
  parameter logic [12:0] J_INIT           = 13'h0001
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_valid,
  output logic        o_start_ready,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_rnd_req,
  input  logic        i_rnd_valid,
  output logic        o_rs_en,
  output logic        o_dp_load,
  output logic        o_state_en,
  output logic        o_busy,
  output logic [3:0]  o_pass_cnt,
  output logic [12:0] o_j_in
);
  localparam int NPASS = NUM_ROUNDS / ROUNDS_PER_CYCLE;
  localparam int LAT_W = $clog2(PASS_LAT) + 1;
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(PASS_LAT - 1);
  localparam logic [3:0]       PASS_LAST = 4'(NPASS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [LAT_W-1:0] r_lat, w_lat_nxt;
  logic [3:0]       r_pass, w_pass_nxt;
  logic             r_start_ready, r_out_valid, r_rnd_req, r_dp_load, r_state_en, r_busy;
  logic             w_rs_en, w_rnd_req_nxt, w_state_en_nxt;
`ifdef XOODOO_CTRL_RND_PREFETCH_EN
  logic             r_pf, w_pf_nxt;
`endif

  // rnd_req is registered and only ever high where randomness may be consumed
  assign w_rs_en = r_rnd_req & i_rnd_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    w_pass_nxt  = r_pass;
`ifdef XOODOO_CTRL_RND_PREFETCH_EN
    w_pf_nxt    = r_pf;
`endif
    case (r_state)
      S_IDLE: if (i_start_valid) w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_pass_nxt  = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (i_rnd_valid) begin
        w_lat_nxt   = '0;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_lat_nxt = r_lat + 1'b1;
`ifdef XOODOO_CTRL_RND_PREFETCH_EN
        if (w_rs_en) w_pf_nxt = 1'b1;
`endif
        if (r_lat == LAT_LAST) begin
          w_lat_nxt = '0;
          if (r_pass == PASS_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_pass_nxt  = r_pass + 1'b1;
            w_state_nxt = S_WAIT;
`ifdef XOODOO_CTRL_RND_PREFETCH_EN
            // a prefetch accepted in this very cycle also counts
            if (r_pf || w_rs_en) begin
              w_state_nxt = S_RUN;
              w_pf_nxt    = 1'b0;
            end
`endif
          end
        end
      end
      S_DONE: if (i_out_ready) begin
        w_pass_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_rnd_req_nxt = (w_state_nxt == S_WAIT);
`ifdef XOODOO_CTRL_RND_PREFETCH_EN
    if (w_state_nxt == S_RUN && w_pass_nxt != PASS_LAST && !w_pf_nxt) w_rnd_req_nxt = 1'b1;
`endif
    w_state_en_nxt = (w_state_nxt == S_LOAD) ||
                     (w_state_nxt == S_RUN && w_lat_nxt == LAT_LAST);
  end

  // outputs are decoded from the next state so every handshake signal leaves a flop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_lat         <= '0;
      r_pass        <= '0;
      r_start_ready <= 1'b1;
      r_out_valid   <= 1'b0;
      r_rnd_req     <= 1'b0;
      r_dp_load     <= 1'b0;
      r_state_en    <= 1'b0;
      r_busy        <= 1'b0;
`ifdef XOODOO_CTRL_RND_PREFETCH_EN
      r_pf          <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_lat         <= w_lat_nxt;
      r_pass        <= w_pass_nxt;
      r_start_ready <= (w_state_nxt == S_IDLE);
      r_out_valid   <= (w_state_nxt == S_DONE);
      r_rnd_req     <= w_rnd_req_nxt;
      r_dp_load     <= (w_state_nxt == S_LOAD);
      r_state_en    <= w_state_en_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
`ifdef XOODOO_CTRL_RND_PREFETCH_EN
      r_pf          <= w_pf_nxt;
`endif
    end
  end

  assign o_start_ready = r_start_ready;
  assign o_out_valid   = r_out_valid;
  assign o_rnd_req     = r_rnd_req;
  assign o_rs_en       = w_rs_en;
  assign o_dp_load     = r_dp_load;
  assign o_state_en    = r_state_en;
  assign o_busy        = r_busy;
  assign o_pass_cnt    = r_pass;
  assign o_j_in        = r_dp_load ? J_INIT : '0;
endmodule
